// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit and HI/LO register file (Execute stage).
//
// Executes mult/multu/div/divu/mthi/mtlo. The result is computed when the
// operation issues. A busy counter then models the latency of the operation,
// and the result commits to HI/LO on the last busy edge.
//
// Optional feature: define MDU_MADD_EN to enable madd (op 6) and msub (op 7).
// These accumulate a signed product into {hi,lo}. Without the macro, both
// ops are no-ops.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu/madd/msub (1-31)
//   DIV_CYCLES   busy cycles for div/divu (1-31)
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle issue pulse
//   md_op     0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub
//   a, b      rs / rt operands
//   md_use_d  Decode-stage instruction touches HI/LO
//   busy      operation in flight
//   md_stall  hold Decode: md_use_d & (busy | start)
//   hi, lo    architectural HI/LO
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        md_use_d,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] phi_q, phi_d;
   logic [31:0] plo_q, plo_d;
   logic        wr_q, wr_d;      // commit enabled (cleared on divide by zero)
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   // ---------------------------------------------------------------------
   // Datapath, evaluated on the issue cycle
   // ---------------------------------------------------------------------
   logic [63:0] sprod, uprod;
   logic        sdiv, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, den, uq, ur, quo, rem;

   // The low 64 bits of a product of sign-extended operands equal the
   // signed 32x32 product.
   assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign uprod = {32'd0, a} * {32'd0, b};

   // Both divides use one unsigned divider. The signed case divides the
   // magnitudes and then fixes up the signs. This truncates toward zero,
   // and the remainder follows the dividend's sign. 0x80000000 / -1 has
   // magnitude 0x80000000 and a positive sign, so it wraps to 0x80000000
   // with remainder 0.
   assign sdiv  = ~md_op[0];
   assign a_neg = sdiv & a[31];
   assign b_neg = sdiv & b[31];
   assign a_mag = a_neg ? (32'd0 - a) : a;
   assign b_mag = b_neg ? (32'd0 - b) : b;
   // A zero divisor gives a result that is never committed. The divisor is
   // forced to 1 only to keep the divider well defined.
   assign den   = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign uq    = a_mag / den;
   assign ur    = a_mag % den;
   assign quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
   assign rem   = a_neg ? (32'd0 - ur) : ur;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      wr_d    = wr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               case (md_op)
                  3'd0: begin
                     {phi_d, plo_d} = sprod;
                     cnt_d   = MULT_N;
                     wr_d    = 1'b1;
                     state_d = RUN;
                  end
                  3'd1: begin
                     {phi_d, plo_d} = uprod;
                     cnt_d   = MULT_N;
                     wr_d    = 1'b1;
                     state_d = RUN;
                  end
                  3'd2, 3'd3: begin
                     phi_d   = rem;
                     plo_d   = quo;
                     cnt_d   = DIV_N;
                     wr_d    = (b != 32'd0);
                     state_d = RUN;
                  end
                  3'd4: hi_d = a;
                  3'd5: lo_d = a;
`ifdef MDU_MADD_EN
                  // The accumulate base is {hi,lo} as it stands at issue.
                  3'd6: begin
                     {phi_d, plo_d} = {hi_q, lo_q} + sprod;
                     cnt_d   = MULT_N;
                     wr_d    = 1'b1;
                     state_d = RUN;
                  end
                  3'd7: begin
                     {phi_d, plo_d} = {hi_q, lo_q} - sprod;
                     cnt_d   = MULT_N;
                     wr_d    = 1'b1;
                     state_d = RUN;
                  end
`endif
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Any start arriving in RUN is dropped, including mthi/mtlo.
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               if (wr_q) begin
                  hi_d = phi_q;
                  lo_d = plo_q;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
         wr_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         wr_q    <= wr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy     = (state_q == RUN);
   // The start term stalls the dependent instruction in the issue cycle
   // itself, before busy has risen.
   assign md_stall = md_use_d & (busy | start);
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit. It runs directed scenarios, then random
// operations. All of them are checked against an arithmetic reference
// model of HI/LO and of the busy latency.
module tb_md_unit;

   localparam int MULT = 5;
   localparam int DIV  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] a_i = 32'd0;
   logic [31:0] b_i = 32'd0;
   logic        md_use_d = 1'b0;
   logic        busy, md_stall;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] mhi = 32'd0;
   logic [31:0] mlo = 32'd0;

   md_unit #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .a(a_i), .b(b_i), .md_use_d(md_use_d),
      .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: the new {hi,lo} and the busy latency of one operation.
   task automatic ref_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] acc, output logic [63:0] res, output int lat);
      longint sx, sy, ux, uy, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      res = acc;
      lat = 0;
      case (op)
         3'd0: begin res = 64'(sx * sy); lat = MULT; end
         3'd1: begin res = 64'(ux * uy); lat = MULT; end
         3'd2: begin
            lat = DIV;
            if (y != 0) begin
               q = sx / sy; r = sx % sy;
               res = {32'(r), 32'(q)};
            end
         end
         3'd3: begin
            lat = DIV;
            if (y != 0) begin
               q = ux / uy; r = ux % uy;
               res = {32'(r), 32'(q)};
            end
         end
         3'd4: res = {x, acc[31:0]};
         3'd5: res = {acc[63:32], x};
`ifdef MDU_MADD_EN
         3'd6: begin res = acc + 64'(sx * sy); lat = MULT; end
         3'd7: begin res = acc - 64'(sx * sy); lat = MULT; end
`endif
         default: ;
      endcase
   endtask

   // Issue one operation, check busy on every cycle of its latency, then
   // check HI/LO against the model.
   task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] ex;
      int lat;
      ref_model(op, x, y, {mhi, mlo}, ex, lat);
      @(negedge clk);
      start = 1'b1; md_op = op; a_i = x; b_i = y;
      @(posedge clk); #1;
      start = 1'b0; a_i = $urandom; b_i = $urandom;
      for (int i = 0; i < lat; i++) begin
         chk("busy_run", {31'd0, busy}, 32'd1);
         @(posedge clk); #1;
      end
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("hi", hi, ex[63:32]);
      chk("lo", lo, ex[31:0]);
      {mhi, mlo} = ex;
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] rx, ry;

      // Reset state
      #12;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); reset = 1'b1;

      // Signed mult
      do_op(3'd0, 32'hFFFFFFFE, 32'd3);
      chk("mult_hi_c", hi, 32'hFFFFFFFF);
      chk("mult_lo_c", lo, 32'hFFFFFFFA);

      // Division variants
      do_op(3'd2, 32'hFFFFFFF9, 32'd2);
      chk("div_lo_c", lo, 32'hFFFFFFFD);
      chk("div_hi_c", hi, 32'hFFFFFFFF);
      do_op(3'd3, 32'hFFFFFFF9, 32'd2);
      chk("divu_lo_c", lo, 32'h7FFFFFFC);
      chk("divu_hi_c", hi, 32'd1);
      do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
      chk("divovf_lo_c", lo, 32'h80000000);
      chk("divovf_hi_c", hi, 32'd0);

      // Divide by zero leaves HI/LO untouched
      do_op(3'd4, 32'h11, 32'd0);
      do_op(3'd5, 32'h22, 32'd0);
      do_op(3'd2, 32'h1234, 32'd0);
      chk("div0_hi_c", hi, 32'h11);
      chk("div0_lo_c", lo, 32'h22);

      // Stall during RUN; an mtlo issued mid-RUN is ignored
      @(negedge clk);
      md_use_d = 1'b1; start = 1'b1; md_op = 3'd0; a_i = 32'd7; b_i = 32'd9;
      #1 chk("stall_issue", {31'd0, md_stall}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < MULT; i++) begin
         chk("stall_busy", {31'd0, busy}, 32'd1);
         chk("stall_run", {31'd0, md_stall}, 32'd1);
         start = (i == 2); md_op = 3'd5; a_i = 32'd5;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("stall_done_busy", {31'd0, busy}, 32'd0);
      chk("stall_hi", hi, 32'd0);
      chk("stall_lo", lo, 32'd63);
      md_use_d = 1'b0;
      #1 chk("stall_clear", {31'd0, md_stall}, 32'd0);
      mhi = 32'd0; mlo = 32'd63;

      // Reset in cycle 3 of a div
      @(negedge clk);
      start = 1'b1; md_op = 3'd2; a_i = 32'd100; b_i = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_hi", hi, 32'd0);
      chk("mid_rst_lo", lo, 32'd63 & 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); reset = 1'b1;
      mhi = 32'd0; mlo = 32'd0;
      do_op(3'd0, 32'd12345, 32'hFFFFFF00);

      // madd: enabled accumulates, disabled is a no-op
      do_op(3'd4, 32'd0, 32'd0);
      do_op(3'd5, 32'hFFFFFFFF, 32'd0);
      do_op(3'd6, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      chk("madd_hi_c", hi, 32'd1);
      chk("madd_lo_c", lo, 32'd0);
`else
      chk("madd_hi_c", hi, 32'd0);
      chk("madd_lo_c", lo, 32'hFFFFFFFF);
`endif

      // Random operations against the model
      for (int n = 0; n < 60; n++) begin
         rop = 3'($urandom_range(0, 7));
         rx  = $urandom;
         ry  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 9)) * (ry[31] ? 32'hFFFFFFFF : 32'd1);
         do_op(rop, rx, ry);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit and HI/LO register file for the pipelined MIPS core. It sits beside the ALU in the Execute stage and executes the mult/multu/div/divu/mthi/mtlo operations flagged by the decoder. A multi-cycle busy counter models the latency of each operation. The block also produces the stall request that holds HI/LO-dependent instructions in Decode.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd/msub when enabled); legal range 1–31.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–31.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  one-cycle pulse from Execute: the operation in `md_op` is issued this cycle.
- `md_op`  in  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub.
- `a`  in  32  rs operand, already forwarded.
- `b`  in  32  rt operand, already forwarded.
- `md_use_d`  in  1  the Decode-stage instruction reads or writes HI/LO (mult/div family, mf*, mt*).
- `busy`  out  1  an operation is in flight.
- `md_stall`  out  1  `md_use_d & (busy | start)`; combinational.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- States: IDLE and RUN; `cnt` is 5 bits wide.
- **IDLE, `start` with op 0–3 (or 6–7 when enabled):**
  - latch the result into pending registers `phi`/`plo`;
  - load `cnt` with N, where N = `MULT_CYCLES` or `DIV_CYCLES`;
  - go to RUN.
- **RUN:** `cnt` decrements each edge. On the edge where `cnt` == 1, commit `phi`/`plo` to `hi`/`lo` and return to IDLE.
- **mthi/mtlo (op 4/5) in IDLE:** write `a` into `hi`/`lo` on the same edge. No busy; the block stays in IDLE.
- **mult:** signed 64-bit product of `a`·`b`; {hi,lo} = product. **multu:** unsigned product.
- **div:** lo = signed quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- **divu:** unsigned quotient and remainder.
- **Divide by zero (`b` == 0):** the unit still goes busy for `DIV_CYCLES`; HI/LO are left unchanged at commit.
- **`start` while busy:** ignored completely, including mthi/mtlo. `md_stall` prevents this in correct pipeline operation.
- **`busy`:** high exactly while in RUN.
- **Reset (any time, including mid-operation):** `hi` = 0, `lo` = 0, `busy` = 0, `cnt` = 0, state = IDLE. Pending results are discarded.

## Timing
- `start` sampled at edge k → `busy` = 1 from edge k up to edge k+N.
- HI/LO show the new value after edge k+N, and `busy` falls at that same edge, so an mfhi/mflo issued after the stall reads the new value.
- mthi/mtlo → new `hi`/`lo` visible after edge k; latency 1.
- `md_stall` asserts in the issue cycle itself, through the `start` term, with no bubble.
- Operands are captured at edge k. Changes to `a`/`b` during RUN have no effect.
- An mthi/mtlo in IDLE and a commit never coincide: a commit only occurs in RUN, and starts are ignored in RUN.

## Configuration
- Macro: `MDU_MADD_EN`.
- **Defined:** op 6 (madd) and op 7 (msub) are enabled.
  - Both use `MULT_CYCLES` of latency.
  - madd: {hi,lo} + signed(`a`·`b`); msub: {hi,lo} − signed(`a`·`b`).
  - Arithmetic is modulo 2^64.
  - The accumulate base is the value of {hi,lo} at the `start` edge.
- **Undefined:** ops 6/7 are no-ops: no busy, HI/LO unchanged.

## Test plan
- **Signed mult:** mult a=0xFFFFFFFE, b=3, N=5.
  - `busy` = 1 for exactly 5 cycles.
  - Then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
- **Division variants:**
  - div a=0xFFFFFFF9 (−7), b=2 → after 10 cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - divu with the same operands → lo = 0x7FFFFFFC, hi = 1.
  - div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Divide by zero:** preload hi = 0x11, lo = 0x22 via mthi/mtlo, then div by 0.
  - `busy` = 1 for 10 cycles.
  - HI/LO remain 0x11/0x22.
- **Stall and ignored start:** during mult RUN, drive `md_use_d` = 1 and `start` with mtlo a=5.
  - `md_stall` = 1 throughout RUN.
  - The mtlo is ignored: lo equals the product after commit, not 5.
- **Reset mid-operation:** pull `reset` low at cycle 3 of a div.
  - Immediately hi = lo = 0 and `busy` = 0.
  - After release, a new mult completes normally.
- **madd (`MDU_MADD_EN` defined):** {hi,lo} = 0x00000000_FFFFFFFF, then madd a=1, b=1 → hi = 1, lo = 0 after 5 cycles.
  - Without the macro, the same operation leaves HI/LO unchanged and `busy` stays 0.
